// File: rtl/hv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hv_mem_pkg
// Purpose  : Shared constants and types for the hypervector RAM read path.
// Revision : 1.0 - initial release
// ============================================================================
package hv_mem_pkg;

  localparam int HV_ADDR_W = 21;
  localparam int HV_DATA_W = 32;
  localparam int HV_LEN_W  = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic                 last;
    logic [HV_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/hv_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hv_sync_fifo
// Purpose  : Small synchronous FIFO with occupancy count (DEPTH power of two).
// Revision : 1.0 - initial release
// ============================================================================
module hv_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (PTR_W+1)'(DEPTH));
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  // A push into a full FIFO is legal only alongside a pop of the head.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hv_word_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : hv_word_fetcher
// Purpose  : Streams a run of consecutive hypervector RAM words to a
//            valid/ready consumer, absorbing the one-cycle RAM latency.
// Revision : 1.0 - initial release
// ============================================================================
module hv_word_fetcher
  import hv_mem_pkg::*;
#(
  parameter int ADDR_W     = HV_ADDR_W,
  parameter int DATA_W     = HV_DATA_W,
  parameter int LEN_W      = HV_LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] raddress,
  input  logic [DATA_W-1:0] rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_raddress;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [LEN_W-1:0]  r_num;
  logic [LEN_W-1:0]  r_issue_idx;
  logic [1:0]        r_cap_valid;
  logic [1:0]        r_cap_last;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_accept;
  logic              w_credit_ok;
  logic              w_pop;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [CNT_W:0]    w_used;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [DATA_W:0]   w_head;

  // Credit counts buffered words plus both latency stages; a same-cycle pop earns nothing.
  assign w_used      = {1'b0, w_fifo_count} + (CNT_W+1)'(r_cap_valid[0]) + (CNT_W+1)'(r_cap_valid[1]);
  assign w_credit_ok = ~w_fifo_full & (w_used < (CNT_W+1)'(FIFO_DEPTH));
  assign w_pop       = m_valid & m_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_issue_addr = r_base + ADDR_W'(r_issue_idx);
    w_issue_last = (r_issue_idx == r_num - LEN_W'(1));
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_accept = 1'b1;
          if (num_words == '0) begin
            w_state_next = FINISH;
          end else begin
            w_issue      = 1'b1;
            w_issue_addr = base_addr;
            w_issue_last = (num_words == LEN_W'(1));
            w_state_next = w_issue_last ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (w_issue_last) w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && m_last) w_state_next = FINISH;
      end
      FINISH: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base      <= '0;
      r_num       <= '0;
      r_issue_idx <= '0;
      r_raddress  <= '0;
      r_cap_valid <= '0;
      r_cap_last  <= '0;
    end else begin
      if (w_accept) begin
        r_base      <= base_addr;
        r_num       <= num_words;
        r_issue_idx <= w_issue ? LEN_W'(1) : '0;
      end else if (w_issue) begin
        r_issue_idx <= r_issue_idx + LEN_W'(1);
      end
      if (w_issue) r_raddress <= w_issue_addr;
      // Stage 0 tracks the address register, stage 1 the RAM output register.
      r_cap_valid <= {r_cap_valid[0], w_issue};
      r_cap_last  <= {r_cap_last[0], w_issue & w_issue_last};
    end
  end

  hv_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_cap_valid[1]),
    .push_data ({r_cap_last[1], rdata}),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  assign raddress = r_raddress;
  assign m_valid  = ~w_fifo_empty;
  assign m_data   = w_head[DATA_W-1:0];
  assign m_last   = w_head[DATA_W] & m_valid;

endmodule
`default_nettype wire

// File: tb/tb_hv_word_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hv_word_fetcher
// Purpose  : Self-checking bench: RAM model plus queue-based reference stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hv_word_fetcher;
  import hv_mem_pkg::*;

  localparam int ADDR_W     = HV_ADDR_W;
  localparam int DATA_W     = HV_DATA_W;
  localparam int LEN_W      = HV_LEN_W;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_words;
  logic              busy, done;
  logic [ADDR_W-1:0] raddress;
  logic [DATA_W-1:0] rdata;
  logic              m_valid, m_ready, m_last;
  logic [DATA_W-1:0] m_data;

  always #5 clk = ~clk;

  hv_word_fetcher #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .raddress(raddress),
    .rdata(rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // RAM content: mem[0x100+i] = 0xA000_0000+i, extended linearly over the whole space.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hA000_0000 + 32'(a) - 32'h100;
  endfunction

  always @(posedge clk) rdata <= mem_word(raddress);

  fifo_entry_t       exp_q[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  int                cyc = 0;
  int                acc_cnt = 0, first_acc = -1, last_acc = -1;
  int                done_cnt = 0, valid_cnt = 0, max_cnt = 0;
  int                rdy_mode = 0;
  logic              stalled = 1'b0;
  fifo_entry_t       held, mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_addr = '0;
      stalled   = 1'b0;
    end else begin
      if (raddress != prev_addr) begin
        if (exp_addr.size() == 0) check_eq("extra_issue", raddress, prev_addr);
        else                      check_eq("raddress", raddress, exp_addr.pop_front());
        prev_addr = raddress;
      end
      if (stalled) begin
        check_eq("stall_valid", m_valid, 1'b1);
        check_eq("stall_hold", {m_last, m_data}, {held.last, held.data});
      end
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_word", m_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("m_data", m_data, mon_e.data);
          check_eq("m_last", m_last, mon_e.last);
        end
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      stalled   = m_valid && !m_ready;
      held.data = m_data;
      held.last = m_last;
      if (done) done_cnt++;
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_cmd(input logic [ADDR_W-1:0] b, input int n);
    fifo_entry_t       e;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + ADDR_W'(i);
      exp_addr.push_back(a);
      e.data = mem_word(a);
      e.last = (i == n - 1);
      exp_q.push_back(e);
      last_addr = a;
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input int n);
    done_cnt  = 0;
    acc_cnt   = 0;
    first_acc = -1;
    expect_cmd(b, n);
    start     = 1'b1;
    base_addr = b;
    num_words = LEN_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    logic got = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (done) begin got = 1'b1; break; end
      tick();
    end
    check_eq(tag, got, 1'b1);
    tick();
    check_eq("busy_after_done", busy, 1'b0);
    check_eq("done_one_cycle", done, 1'b0);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("words_left", exp_q.size(), 0);
    check_eq("issues_left", exp_addr.size(), 0);
  endtask

  task automatic run_cmd(input logic [ADDR_W-1:0] b, input int n);
    pulse_start(b, n);
    wait_done("done_timeout", n * 8 + 40);
  endtask

  initial begin
    logic [ADDR_W-1:0] rb;
    int                rn;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    tick(); tick();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_raddress", raddress, '0);
    check_eq("rst_out", {m_valid, m_last, m_data}, '0);
    reset = 1'b0;
    tick();

    // Basic stream with full-rate consumer and latency checks.
    rdy_mode = 0;
    pulse_start(21'h100, 4);
    check_eq("t1_raddr_k", raddress, 21'h100);
    check_eq("t1_valid_k", m_valid, 1'b0);
    check_eq("t1_busy_k", busy, 1'b1);
    tick();
    check_eq("t1_valid_k1", m_valid, 1'b0);
    tick();
    check_eq("t1_valid_k2", m_valid, 1'b1);
    check_eq("t1_first_data", m_data, 32'hA000_0000);
    wait_done("t1_done", 40);
    check_eq("t1_back_to_back", last_acc - first_acc, 3);

    // Consumer ready one cycle in three.
    rdy_mode = 1;
    run_cmd(21'h100, 4);

    // Zero-length command; start held into the done cycle must be ignored.
    rdy_mode  = 0;
    done_cnt  = 0;
    start     = 1'b1; base_addr = 21'h100; num_words = '0;
    tick();
    check_eq("t3_busy", busy, 1'b1);
    check_eq("t3_done", done, 1'b1);
    valid_cnt = 0;
    base_addr = 21'h400; num_words = LEN_W'(3);
    tick();
    start = 1'b0;
    check_eq("t3_busy_low", busy, 1'b0);
    check_eq("t3_done_low", done, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check_eq("t3_raddr_kept", raddress, 21'h103);
    check_eq("t3_no_valid", valid_cnt, 0);
    check_eq("t3_done_pulses", done_cnt, 1);

    // Address wrap at the top of the RAM.
    rdy_mode = 2;
    run_cmd(21'h1FFFFE, 4);

    // Reset mid-fetch after two words accepted.
    rdy_mode = 0;
    pulse_start(21'h100, 8);
    for (int i = 0; i < 20 && acc_cnt < 2; i++) tick();
    check_eq("t5_two_accepted", acc_cnt >= 2, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    exp_addr.delete();
    tick();
    reset = 1'b0;
    check_eq("t5_rst_state", {busy, done, m_valid, m_last}, '0);
    check_eq("t5_rst_raddr", raddress, '0);
    check_eq("t5_rst_data", m_data, '0);
    valid_cnt = 0;
    tick(); tick(); tick();
    check_eq("t5_no_stale", valid_cnt, 0);
    run_cmd(21'h200, 2);

    // Start while busy is ignored.
    rdy_mode = 1;
    pulse_start(21'h100, 8);
    tick(); tick(); tick();
    start = 1'b1; base_addr = 21'h300; num_words = LEN_W'(5);
    tick();
    start = 1'b0;
    wait_done("t6_done", 120);
    valid_cnt = 0;
    for (int i = 0; i < 8; i++) tick();
    check_eq("t6_no_second_cmd", valid_cnt, 0);

    // Randomised commands.
    rdy_mode = 2;
    for (int t = 0; t < 15; t++) begin
      rb = ADDR_W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 21'h1FFFFF - ADDR_W'($urandom_range(0, 5));
      if (rb == last_addr) rb = rb ^ 21'h1;
      rn = $urandom_range(0, 20);
      run_cmd(rb, rn);
    end

    check_eq("fifo_count_bound", max_cnt > FIFO_DEPTH, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
